// File: rtl/ps2_command_tx.sv
// Host-to-device PS/2 command transmitter: inhibit, request-to-send,
// clock out one byte with odd parity, then collect the device ack.
module ps2_command_tx #(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int TIMEOUT_CYCLES = 750000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       send,
    input  logic [7:0] cmd_data,
    input  logic       ps2_clk_in,
    input  logic       ps2_dat_in,
    output logic       ps2_clk_oe,
    output logic       ps2_dat_oe,
    output logic       busy,
    output logic       done,
    output logic       error
);

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        REQ,
        SEND,
        ACK,
        WAIT_IDLE,
        FINISH
    } state_t;

    localparam logic [19:0] INHIBIT_LAST = 20'(INHIBIT_CYCLES - 1);
    localparam logic [19:0] TIMEOUT_LAST = 20'(TIMEOUT_CYCLES - 1);

    state_t      state_q, state_d;
    logic [1:0]  clk_sync_q, clk_sync_d;
    logic [1:0]  dat_sync_q, dat_sync_d;
    logic        clk_prev_q, clk_prev_d;
    logic [7:0]  data_q, data_d;
    logic [3:0]  bitcnt_q, bitcnt_d;
    logic [19:0] timer_q, timer_d;
    logic        clk_oe_q, clk_oe_d;
    logic        dat_oe_q, dat_oe_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        error_q, error_d;

    logic clk_s, dat_s, clk_fall, timeout, device_phase;

    assign clk_s        = clk_sync_q[1];
    assign dat_s        = dat_sync_q[1];
    assign clk_fall     = clk_prev_q & ~clk_s;
    assign timeout      = (timer_q == TIMEOUT_LAST);
    // Edges seen while the host itself holds the clock low are not device edges.
    assign device_phase = (state_q == SEND) || (state_q == ACK) ||
                          (state_q == WAIT_IDLE);

    always_comb begin
        clk_sync_d = {clk_sync_q[0], ps2_clk_in};
        dat_sync_d = {dat_sync_q[0], ps2_dat_in};
        clk_prev_d = clk_s;
        state_d    = state_q;
        data_d     = data_q;
        bitcnt_d   = bitcnt_q;
        clk_oe_d   = clk_oe_q;
        dat_oe_d   = dat_oe_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        error_d    = 1'b0;
        timer_d    = timer_q + 20'd1;

        unique case (state_q)
            IDLE: begin
                clk_oe_d = 1'b0;
                dat_oe_d = 1'b0;
                timer_d  = 20'd0;
                if (send) begin
                    data_d   = cmd_data;
                    busy_d   = 1'b1;
                    clk_oe_d = 1'b1;
                    state_d  = INHIBIT;
                end
            end
            INHIBIT: begin
                if (timer_q == INHIBIT_LAST) begin
                    dat_oe_d = 1'b1;
                    state_d  = REQ;
                end
            end
            REQ: begin
                clk_oe_d = 1'b0;
                bitcnt_d = 4'd0;
                state_d  = SEND;
            end
            SEND: begin
                if (timeout) begin
                    clk_oe_d = 1'b0;
                    dat_oe_d = 1'b0;
                    done_d   = 1'b1;
                    error_d  = 1'b1;
                    state_d  = FINISH;
                end else if (clk_fall) begin
                    bitcnt_d = bitcnt_q + 4'd1;
                    if (bitcnt_q < 4'd8) begin
                        dat_oe_d = ~data_q[bitcnt_q[2:0]];
                    end else if (bitcnt_q == 4'd8) begin
                        dat_oe_d = ^data_q;
                    end else begin
                        dat_oe_d = 1'b0;
                        state_d  = ACK;
                    end
                end
            end
            ACK: begin
                if (timeout || (clk_fall && dat_s)) begin
                    clk_oe_d = 1'b0;
                    dat_oe_d = 1'b0;
                    done_d   = 1'b1;
                    error_d  = 1'b1;
                    state_d  = FINISH;
                end else if (clk_fall) begin
                    state_d = WAIT_IDLE;
                end
            end
            WAIT_IDLE: begin
                if (timeout) begin
                    clk_oe_d = 1'b0;
                    dat_oe_d = 1'b0;
                    done_d   = 1'b1;
                    error_d  = 1'b1;
                    state_d  = FINISH;
                end else if (clk_s && dat_s) begin
                    done_d  = 1'b1;
                    state_d = FINISH;
                end
            end
            FINISH: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                clk_oe_d = 1'b0;
                dat_oe_d = 1'b0;
                busy_d   = 1'b0;
                state_d  = IDLE;
            end
        endcase

        if ((state_d != state_q) || (clk_fall && device_phase)) begin
            timer_d = 20'd0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            clk_sync_q <= 2'b11;
            dat_sync_q <= 2'b11;
            clk_prev_q <= 1'b1;
            data_q     <= 8'd0;
            bitcnt_q   <= 4'd0;
            timer_q    <= 20'd0;
            clk_oe_q   <= 1'b0;
            dat_oe_q   <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            clk_sync_q <= clk_sync_d;
            dat_sync_q <= dat_sync_d;
            clk_prev_q <= clk_prev_d;
            data_q     <= data_d;
            bitcnt_q   <= bitcnt_d;
            timer_q    <= timer_d;
            clk_oe_q   <= clk_oe_d;
            dat_oe_q   <= dat_oe_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            error_q    <= error_d;
        end
    end

    assign ps2_clk_oe = clk_oe_q;
    assign ps2_dat_oe = dat_oe_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign error      = error_q;

endmodule

// File: tb/tb_ps2_command_tx.sv
// Bench for ps2_command_tx: a behavioural PS/2 device on wired-AND lines
// checks the frames it clocks in against a frame model of the byte.
module tb_ps2_command_tx;

    localparam int INH = 40;
    localparam int TO  = 600;

    logic       clock    = 1'b0;
    logic       reset    = 1'b1;
    logic       send     = 1'b0;
    logic [7:0] cmd_data = 8'd0;
    logic       dev_clk  = 1'b1;
    logic       dev_dat  = 1'b1;
    logic       ps2_clk_in, ps2_dat_in;
    logic       ps2_clk_oe, ps2_dat_oe;
    logic       busy, done, error;

    int total    = 0;
    int bad      = 0;
    int done_cnt = 0;

    assign ps2_clk_in = dev_clk & ~ps2_clk_oe;
    assign ps2_dat_in = dev_dat & ~ps2_dat_oe;

    ps2_command_tx #(
        .INHIBIT_CYCLES(INH),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .send       (send),
        .cmd_data   (cmd_data),
        .ps2_clk_in (ps2_clk_in),
        .ps2_dat_in (ps2_dat_in),
        .ps2_clk_oe (ps2_clk_oe),
        .ps2_dat_oe (ps2_dat_oe),
        .busy       (busy),
        .done       (done),
        .error      (error)
    );

    always #5 clock = ~clock;

    always @(negedge clock) if (done === 1'b1) done_cnt++;

    initial begin
        #900000;
        $display("FAIL watchdog: got no finish, expected finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Start, 8 data bits LSB first, odd parity, stop.
    function automatic logic [10:0] frame_of(input logic [7:0] b);
        logic p;
        p = (($countones(b) % 2) == 0);
        return {1'b1, p, b, 1'b0};
    endfunction

    task automatic start_txn(input logic [7:0] b, output int low_len);
        @(negedge clock);
        cmd_data = b;
        send = 1'b1;
        @(negedge clock);
        send = 1'b0;
        cmd_data = 8'($urandom);
        check("accept_busy", busy, 1);
        check("accept_clk_oe", ps2_clk_oe, 1);
        low_len = 0;
        while (ps2_clk_oe === 1'b1 && low_len < INH + 100) begin
            @(negedge clock);
            low_len++;
        end
    endtask

    task automatic device_bits(input int hp, input int nfall,
                               output logic [10:0] seen);
        seen = '0;
        repeat (3) @(negedge clock);
        seen[0] = ps2_dat_in;
        for (int k = 1; k <= nfall; k++) begin
            dev_clk = 1'b0;
            repeat (hp) @(negedge clock);
            dev_clk = 1'b1;
            repeat (hp / 2) @(negedge clock);
            seen[k] = ps2_dat_in;
            repeat (hp - hp / 2) @(negedge clock);
        end
    endtask

    task automatic device_ack(input int hp, input bit ack);
        dev_dat = ~ack;
        repeat (hp / 2) @(negedge clock);
        dev_clk = 1'b0;
        repeat (hp) @(negedge clock);
        dev_clk = 1'b1;
        repeat (hp / 2) @(negedge clock);
        dev_dat = 1'b1;
    endtask

    task automatic wait_done(input int lim, input logic exp_err);
        int n;
        n = 0;
        while (done !== 1'b1 && n < lim) begin
            @(negedge clock);
            n++;
        end
        check("done_seen", done, 1);
        check("done_error", error, exp_err);
        @(negedge clock);
        check("busy_after_done", busy, 0);
        check("done_one_cycle", done, 0);
    endtask

    task automatic run_txn(input logic [7:0] b, input bit ack, input int hp);
        int low_len, d0;
        logic [10:0] seen;
        d0 = done_cnt;
        start_txn(b, low_len);
        check("clk_low_len", low_len, INH + 1);
        check("start_held", ps2_dat_oe, 1);
        device_bits(hp, 10, seen);
        check("frame", seen, frame_of(b));
        fork
            device_ack(hp, ack);
            wait_done(8 * hp + 50, ~ack);
        join
        repeat (2) @(negedge clock);
        check("done_count", done_cnt - d0, 1);
    endtask

    initial begin
        logic [10:0] seen, f;
        int n, d0;
        logic [7:0] b;
        bit ack;

        repeat (3) @(negedge clock);
        check("rst_clk_oe", ps2_clk_oe, 0);
        check("rst_dat_oe", ps2_dat_oe, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_error", error, 0);
        reset = 1'b0;
        repeat (3) @(negedge clock);

        run_txn(8'hF4, 1'b1, 20);
        run_txn(8'hED, 1'b1, 16);
        run_txn(8'hFF, 1'b0, 20);

        // Timeout with send held high across FINISH.
        @(negedge clock);
        cmd_data = 8'hFF;
        send = 1'b1;
        @(negedge clock);
        check("to_accept_busy", busy, 1);
        n = 0;
        while (ps2_clk_oe === 1'b1 && n < INH + 100) begin
            @(negedge clock);
            n++;
        end
        check("to_clk_low_len", n, INH + 1);
        n = 0;
        while (done !== 1'b1 && n < TO + 100) begin
            @(negedge clock);
            n++;
        end
        check("to_latency", n, TO);
        check("to_error", error, 1);
        check("to_clk_rel", ps2_clk_oe, 0);
        check("to_dat_rel", ps2_dat_oe, 0);
        @(negedge clock);
        check("finish_ignores_send", busy, 0);
        @(negedge clock);
        check("held_send_accepted", busy, 1);
        send = 1'b0;
        n = 0;
        while (done !== 1'b1 && n < TO + INH + 100) begin
            @(negedge clock);
            n++;
        end
        check("to2_done", done, 1);
        check("to2_error", error, 1);
        repeat (2) @(negedge clock);

        // A send pulse during an active frame must be dropped.
        d0 = done_cnt;
        fork
            run_txn(8'hF4, 1'b1, 20);
            begin
                repeat (INH + 150) @(negedge clock);
                cmd_data = 8'h11;
                send = 1'b1;
                @(negedge clock);
                send = 1'b0;
            end
        join
        repeat (60) @(negedge clock);
        check("busy_ignored_idle", busy, 0);
        check("busy_ignored_clk", ps2_clk_oe, 0);
        check("busy_one_done", done_cnt - d0, 1);

        // Reset after the 4th falling edge.
        d0 = done_cnt;
        f = frame_of(8'hF4);
        start_txn(8'hF4, n);
        device_bits(20, 4, seen);
        check("pre_rst_bits", seen[4:0], f[4:0]);
        check("pre_rst_dat_oe", ps2_dat_oe, 1);
        #2 reset = 1'b1;
        #1;
        check("mid_rst_clk_oe", ps2_clk_oe, 0);
        check("mid_rst_dat_oe", ps2_dat_oe, 0);
        check("mid_rst_busy", busy, 0);
        repeat (4) @(negedge clock);
        reset = 1'b0;
        repeat (4) @(negedge clock);
        check("mid_rst_no_done", done_cnt - d0, 0);
        run_txn(8'hF4, 1'b1, 20);

        for (int i = 0; i < 5; i++) begin
            b = 8'($urandom);
            ack = ($urandom_range(0, 3) != 0);
            run_txn(b, ack, $urandom_range(10, 30));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ps2_command_tx.md
# ps2_command_tx

Host-to-device PS/2 transmitter. It sends one command byte to the keyboard on the shared open-collector PS2_CLK/PS2_DAT lines, for example 0xED (set LEDs), 0xF4 (enable) or 0xFF (reset). It is the outbound counterpart of the keyboard_tracker receive path and sits beside it in the othello top level. The top level converts the drive-low enables into tri-states, for example `PS2_CLK = ps2_clk_oe ? 1'b0 : 1'bz`, and gates keyboard_tracker input while `busy` is high.

## Interface

Parameters:
- INHIBIT_CYCLES, 5000 — clock-low request hold (100 µs at 50 MHz).
- TIMEOUT_CYCLES, 750000 — maximum wait for any expected device event (15 ms at 50 MHz).

Ports:
- clock  in  1  — system clock (CLOCK_50).
- reset  in  1  — asynchronous, active-high reset.
- send  in  1  — request strobe. Sampled only in IDLE.
- cmd_data  in  8  — command byte. Captured in the cycle that `send` is accepted.
- ps2_clk_in  in  1  — raw PS2_CLK pin value. Asynchronous.
- ps2_dat_in  in  1  — raw PS2_DAT pin value. Asynchronous.
- ps2_clk_oe  out  1  — 1 drives PS2_CLK low; 0 releases it.
- ps2_dat_oe  out  1  — 1 drives PS2_DAT low; 0 releases it.
- busy  out  1  — high from acceptance until `done`.
- done  out  1  — one-cycle pulse when the transaction ends, successfully or not.
- error  out  1  — one-cycle pulse coincident with `done` on NACK or timeout.

## Operation

- Input sync: `ps2_clk_in` and `ps2_dat_in` each pass through a 2-flop synchronizer. `clk_fall` = previous synced clock high AND current synced clock low.
- Parity: odd. `par = ~^cmd_data`.
- Bit counter: 4 bits.
- Timer: 20 bits. It clears on every state change and on every `clk_fall`.
- Reset values: state IDLE; ps2_clk_oe=0, ps2_dat_oe=0, busy=0, done=0, error=0; counters 0.

State machine:
- IDLE
  - Both lines released.
  - If `send`=1: latch `cmd_data`, set busy=1, go to INHIBIT.
- INHIBIT
  - ps2_clk_oe=1 for INHIBIT_CYCLES cycles, then go to REQ.
- REQ
  - ps2_clk_oe=1 and ps2_dat_oe=1 for exactly 1 cycle (start bit presented).
  - Then go to SEND with bitcnt=0.
- SEND
  - ps2_clk_oe=0; the device now generates the clock.
  - ps2_dat_oe holds the current bit inverted. Before the first `clk_fall` the start bit is held (dat_oe=1).
  - On each `clk_fall`, bitcnt increments and the new bit is driven:
    - bitcnt 1..8 → `cmd_data[bitcnt-1]`, LSB first.
    - bitcnt 9 → parity.
    - bitcnt 10 → stop (dat_oe=0, line released).
  - The `clk_fall` after bitcnt=10 goes to ACK.
- ACK
  - Waits for the next `clk_fall` (the 11th falling edge) and samples synced data there.
  - Data 0 → ack, go to WAIT_IDLE.
  - Data 1 → NACK, go to FINISH with the error flag set.
- WAIT_IDLE
  - Waits until synced clock=1 and synced data=1 in the same cycle, then goes to FINISH.
- FINISH
  - done=1 (and error=1 if flagged) for one cycle; busy=0 from the next cycle.
  - Returns to IDLE.
- Timeout: in SEND, ACK or WAIT_IDLE, if the timer reaches TIMEOUT_CYCLES-1:
  - release both lines at once;
  - go to FINISH with the error flag set.

Boundary and corner cases:
- `send` while busy: ignored, not queued.
- `send` in the same cycle as a FINISH pulse: ignored.
- `send` held high: accepted again on the first IDLE cycle after FINISH.
- `clk_fall` during INHIBIT or REQ (the host is driving the clock itself): ignored.
- Reset asserted mid-transaction: both oe signals drop asynchronously, the state returns to IDLE, and no done/error pulse is produced.

## Timing

- Acceptance: `send` is registered; busy=1 and ps2_clk_oe=1 in the cycle after `send` is sampled.
- ps2_clk_oe stays high for INHIBIT_CYCLES + 1 cycles (INHIBIT plus REQ).
- Each data-line update follows a physical falling edge of the device clock by 3 cycles: 2 synchronizer stages plus the edge register.
  - That is about 60 ns, far inside the device's ~40 µs half-period.
- `done`, `error` and busy deassertion are all registered; none is a combinational function of the inputs.
- The ps2_clk_oe/ps2_dat_oe outputs are registered and glitch-free.

## Test plan

- **Send 0xF4:** a device model clocks at 12 kHz after seeing clock low ≥100 µs.
  - Required: clock held low exactly 5001 cycles.
  - Required: the device sees bits 0,0,1,0,1,1,1,1, parity 0, stop 1.
  - Model acks → done=1, error=0, busy=0 next cycle.
- **Send 0xED:** required bits 1,0,1,1,0,1,1,1 and parity 1; ack → done with error=0.
- **NACK:** send 0xFF; the model leaves data high at the 11th falling edge → done=1 and error=1 in the same cycle.
- **Timeout:** send 0xFF with no device clocking.
  - Required: both lines released and done=error=1 exactly TIMEOUT_CYCLES cycles after REQ.
- **Busy handling:** pulse send with 0x11 during an active 0xF4 transaction → the 0xF4 frame is unchanged and only one done pulse occurs.
- **Reset mid-SEND:** assert reset after the 4th falling edge.
  - Required: oe outputs fall in the same cycle and no done pulse.
  - A following send of 0xF4 completes normally.
